dsp_mem_framesync_wide: RTL and testbench
=========================================

DSP_MEM_FRAMESYNC_WIDE -- requirements
Module: dsp_mem_framesync_wide

Interface
REQ-001 Parameter FrameLength, default 64, frame/syncword length in bits; SHALL be a multiple of Width.
REQ-002 Parameter Width, default 4, bits shifted per read-clock cycle; 1 <= Width <= FrameLength.
REQ-003 Parameter CntWidth, default 16, width of completed-frame counter.
REQ-004 Derived: NumWords = FrameLength/Width; PosWidth = max(1, $clog2(NumWords)).
REQ-005 Port i_rclk  input  1  read clock; the only clock.
REQ-006 Port i_rrst  input  1  reset, synchronous to i_rclk, active-high.
REQ-007 Port i_cfg_mode_load  input  1  load syncword (highest priority).
REQ-008 Port i_cfg_mode_rshift  input  1  enable per-cycle shift.
REQ-009 Port i_cfg_mode_rotate  input  1  recirculate head word into tail instead of i_tail_fs_mem.
REQ-010 Port i_cfg_cnt_clr  input  1  clear frame counter.
REQ-011 Port i_cfg_syncword  input  FrameLength  value loaded in load mode.
REQ-012 Port i_tail_fs_mem  input  Width  tail fill word from upstream.
REQ-013 Port o_head_fs_mem  output  Width  head word, equal to framesync[FrameLength-1 -: Width].
REQ-014 Port o_sof  output  1  start-of-frame strobe.
REQ-015 Port o_pos  output  PosWidth  word index of current head within frame.
REQ-016 Port o_frame_cnt  output  CntWidth  completed-frame count, saturating.

Function
REQ-017 Registers: framesync[FrameLength-1:0], pos, frame_cnt, rshift_q, rotate_q.
REQ-018 rshift_q/rotate_q SHALL register i_cfg_mode_rshift/i_cfg_mode_rotate each cycle; mode changes take effect one cycle after input change.
REQ-019 i_cfg_mode_load SHALL act unregistered: framesync <= i_cfg_syncword, pos <= 0, frame_cnt <= 0 next edge, regardless of rshift_q.
REQ-020 Shift (rshift_q=1, load=0): framesync <= {framesync[FrameLength-Width-1:0], tail}; for Width==FrameLength framesync <= tail.
REQ-021 tail = rotate_q ? framesync[FrameLength-1 -: Width] : i_tail_fs_mem.
REQ-022 Bit order MSB-first: o_head_fs_mem[Width-1] is the earliest frame bit of the word.
REQ-023 Hold (load=0, rshift_q=0): all state unchanged.
REQ-024 pos SHALL advance on each shift, wrapping NumWords-1 -> 0; unchanged when holding.
REQ-025 o_sof = rshift_q & ~i_cfg_mode_load & (pos==0); combinational from registers and load.
REQ-026 frame_cnt SHALL increment on a shift with pos==NumWords-1; saturate at 2^CntWidth-1 (no wrap).
REQ-027 i_cfg_cnt_clr SHALL zero frame_cnt next edge, overriding an increment in the same cycle; does not affect framesync or pos.
REQ-028 Load and clr together: load result applies (all cleared).
REQ-029 Width==FrameLength: pos constant 0, o_sof high every shift cycle, frame_cnt increments every shift.
REQ-030 All outputs SHALL derive from registers (plus load for o_sof); no combinational path from i_tail_fs_mem to outputs.

Reset
REQ-031 On i_rrst=1 at rising edge: framesync=0, pos=0, frame_cnt=0, rshift_q=0, rotate_q=0; reset overrides load.
REQ-032 After reset: o_head_fs_mem=0, o_sof=0, o_pos=0, o_frame_cnt=0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; no count increment that cycle.

Verification (FrameLength=16, Width=4, CntWidth=4)
REQ-034 Load 0xA5C3, then rshift=1, rotate=0, tail=0x0 -> head 0xA (sof=1, pos=0), one cycle later than rshift rises; then 0x5,0xC,0x3,0x0; frame_cnt=1 after the 4th shift.
REQ-035 Load 0xA5C3, rshift=1, rotate=1 for 12 shifts -> head repeats A,5,C,3 three times; sof on each A; frame_cnt=3.
REQ-036 Rotate continuous for 80 shifts -> frame_cnt saturates at 15; cnt_clr pulse -> 0, then resumes at next wrap.
REQ-037 Shift to pos=2, assert load 0x1234 -> next cycle head 0x1, pos=0, frame_cnt=0, sof=1 if rshift_q still high.
REQ-038 Shifting at pos=3 with i_rrst=1 -> all outputs zero next cycle, frame_cnt stays 0; load+reset together -> reset wins.
REQ-039 Deassert rshift mid-frame at pos=1 -> state holds one extra shift (registered mode), then frozen; reassert resumes at same word.

Source files
------------

// File: rtl/dsp_mem_framesync_wide.sv
// dsp_mem_framesync_wide: word-wide frame/syncword shift register with frame position, SOF strobe and saturating frame counter
module dsp_mem_framesync_wide #(
    parameter int FrameLength = 64,
    parameter int Width = 4,
    parameter int CntWidth = 16,
    localparam int NumWords = FrameLength / Width,
    localparam int PosWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                   i_rclk,
    input  logic                   i_rrst,
    input  logic                   i_cfg_mode_load,
    input  logic                   i_cfg_mode_rshift,
    input  logic                   i_cfg_mode_rotate,
    input  logic                   i_cfg_cnt_clr,
    input  logic [FrameLength-1:0] i_cfg_syncword,
    input  logic [Width-1:0]       i_tail_fs_mem,
    output logic [Width-1:0]       o_head_fs_mem,
    output logic                   o_sof,
    output logic [PosWidth-1:0]    o_pos,
    output logic [CntWidth-1:0]    o_frame_cnt
);
    localparam logic [PosWidth-1:0] PosLast = PosWidth'(NumWords - 1);
    logic [FrameLength-1:0] framesync, framesync_next, shifted;
    logic [PosWidth-1:0]    pos, pos_next;
    logic [CntWidth-1:0]    frame_cnt, frame_cnt_next;
    logic                   rshift_q, rotate_q, wrap;
    logic [Width-1:0]       head, tail;
    assign head = framesync[FrameLength-1 -: Width];
    assign tail = rotate_q ? head : i_tail_fs_mem;
    generate
        if (Width == FrameLength) begin : g_full
            assign shifted = tail;
        end else begin : g_part
            assign shifted = {framesync[FrameLength-Width-1:0], tail};
        end
    endgenerate
    assign wrap = rshift_q && (pos == PosLast);
    always_comb begin
        framesync_next = i_cfg_mode_load ? i_cfg_syncword : rshift_q ? shifted : framesync;
        pos_next       = i_cfg_mode_load ? '0 : !rshift_q ? pos : wrap ? '0 : pos + PosWidth'(1);
        frame_cnt_next = (i_cfg_mode_load || i_cfg_cnt_clr) ? '0 :
                         (wrap && frame_cnt != '1) ? frame_cnt + CntWidth'(1) : frame_cnt;
    end
    always_ff @(posedge i_rclk) begin
        if (i_rrst) begin
            framesync <= '0;
            pos       <= '0;
            frame_cnt <= '0;
            rshift_q  <= 1'b0;
            rotate_q  <= 1'b0;
        end else begin
            framesync <= framesync_next;
            pos       <= pos_next;
            frame_cnt <= frame_cnt_next;
            rshift_q  <= i_cfg_mode_rshift;
            rotate_q  <= i_cfg_mode_rotate;
        end
    end
    assign o_head_fs_mem = head;
    assign o_sof         = rshift_q & ~i_cfg_mode_load & (pos == '0);
    assign o_pos         = pos;
    assign o_frame_cnt   = frame_cnt;
endmodule

// File: tb/tb_dsp_mem_framesync_wide.sv
// tb_dsp_mem_framesync_wide: directed vector table plus hand sequences for rotation, saturation and mid-frame load
module tb_dsp_mem_framesync_wide;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, ld, rs, ro, clr;
    logic [15:0] sw;
    logic [3:0] tail, head, cnt;
    logic sof;
    logic [1:0] pos;
    dsp_mem_framesync_wide #(.FrameLength(16), .Width(4), .CntWidth(4)) dut (
        .i_rclk(clk),
        .i_rrst(rst),
        .i_cfg_mode_load(ld),
        .i_cfg_mode_rshift(rs),
        .i_cfg_mode_rotate(ro),
        .i_cfg_cnt_clr(clr),
        .i_cfg_syncword(sw),
        .i_tail_fs_mem(tail),
        .o_head_fs_mem(head),
        .o_sof(sof),
        .o_pos(pos),
        .o_frame_cnt(cnt)
    );
    typedef struct {
        logic rst, ld, rs, ro, clr;
        logic [15:0] sw;
        logic [3:0] tail;
        logic [3:0] head;
        logic sof;
        logic [1:0] pos;
        logic [3:0] cnt;
    } vec_t;
    vec_t vt[31];
    logic [3:0] words[4];
    int total = 0;
    int bad = 0;
    function automatic vec_t mk(input logic r, l, s, o, c, input logic [15:0] w, input logic [3:0] t,
                                input logic [3:0] h, input logic f, input logic [1:0] p, input logic [3:0] n);
        mk = '{r, l, s, o, c, w, t, h, f, p, n};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        {rst, ld, rs, ro, clr} = '0;
        sw = '0;
        tail = '0;
        words = '{4'hA, 4'h5, 4'hC, 4'h3};
        //         rst ld rs ro clr sw        tail   head  sof pos cnt
        vt[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
        vt[1]  = mk(0, 1, 0, 0, 0, 16'hA5C3, 4'h0, 4'hA, 0, 0, 0);
        vt[2]  = mk(0, 0, 1, 0, 0, 16'h0000, 4'h0, 4'hA, 1, 0, 0);
        vt[3]  = mk(0, 0, 1, 0, 0, 16'h0000, 4'h0, 4'h5, 0, 1, 0);
        vt[4]  = mk(0, 0, 1, 0, 0, 16'h0000, 4'h0, 4'hC, 0, 2, 0);
        vt[5]  = mk(0, 0, 1, 0, 0, 16'h0000, 4'h0, 4'h3, 0, 3, 0);
        vt[6]  = mk(0, 0, 1, 0, 0, 16'h0000, 4'h0, 4'h0, 1, 0, 1);
        vt[7]  = mk(0, 0, 1, 0, 0, 16'h0000, 4'h9, 4'h0, 0, 1, 1);
        vt[8]  = mk(0, 0, 1, 0, 0, 16'h0000, 4'h8, 4'h0, 0, 2, 1);
        vt[9]  = mk(0, 0, 1, 0, 0, 16'h0000, 4'h7, 4'h0, 0, 3, 1);
        vt[10] = mk(0, 0, 1, 0, 0, 16'h0000, 4'h6, 4'h9, 1, 0, 2);
        vt[11] = mk(0, 0, 1, 0, 0, 16'h0000, 4'h1, 4'h8, 0, 1, 2);
        vt[12] = mk(0, 0, 0, 0, 0, 16'h0000, 4'h2, 4'h7, 0, 2, 2);
        vt[13] = mk(0, 0, 0, 0, 0, 16'h0000, 4'hF, 4'h7, 0, 2, 2);
        vt[14] = mk(0, 0, 0, 0, 0, 16'h0000, 4'hF, 4'h7, 0, 2, 2);
        vt[15] = mk(0, 0, 1, 0, 0, 16'h0000, 4'hF, 4'h7, 0, 2, 2);
        vt[16] = mk(0, 0, 1, 0, 0, 16'h0000, 4'h3, 4'h6, 0, 3, 2);
        vt[17] = mk(0, 0, 1, 0, 0, 16'h0000, 4'h4, 4'h1, 1, 0, 3);
        vt[18] = mk(0, 0, 1, 0, 0, 16'h0000, 4'h5, 4'h2, 0, 1, 3);
        vt[19] = mk(0, 0, 1, 0, 0, 16'h0000, 4'h6, 4'h3, 0, 2, 3);
        vt[20] = mk(0, 0, 1, 0, 0, 16'h0000, 4'h7, 4'h4, 0, 3, 3);
        vt[21] = mk(1, 0, 1, 0, 0, 16'h0000, 4'h8, 4'h0, 0, 0, 0);
        vt[22] = mk(1, 1, 1, 0, 0, 16'hFFFF, 4'h0, 4'h0, 0, 0, 0);
        vt[23] = mk(0, 0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
        vt[24] = mk(0, 1, 1, 1, 0, 16'hA5C3, 4'h0, 4'hA, 0, 0, 0);
        vt[25] = mk(0, 0, 1, 1, 0, 16'h0000, 4'hF, 4'h5, 0, 1, 0);
        vt[26] = mk(0, 0, 1, 1, 0, 16'h0000, 4'hF, 4'hC, 0, 2, 0);
        vt[27] = mk(0, 0, 1, 1, 0, 16'h0000, 4'hF, 4'h3, 0, 3, 0);
        vt[28] = mk(0, 0, 1, 1, 1, 16'h0000, 4'hF, 4'hA, 1, 0, 0);
        vt[29] = mk(0, 0, 1, 1, 0, 16'h0000, 4'hF, 4'h5, 0, 1, 0);
        vt[30] = mk(0, 1, 1, 1, 1, 16'hBEEF, 4'hF, 4'hB, 0, 0, 0);
        for (int i = 0; i < 31; i++) begin
            {rst, ld, rs, ro, clr} = {vt[i].rst, vt[i].ld, vt[i].rs, vt[i].ro, vt[i].clr};
            sw = vt[i].sw;
            tail = vt[i].tail;
            step();
            check($sformatf("v%0d head", i), 32'(head), 32'(vt[i].head));
            check($sformatf("v%0d sof", i), 32'(sof), 32'(vt[i].sof));
            check($sformatf("v%0d pos", i), 32'(pos), 32'(vt[i].pos));
            check($sformatf("v%0d cnt", i), 32'(cnt), 32'(vt[i].cnt));
        end
        // continuous rotation of a loaded syncword
        {rst, ld, rs, ro, clr} = 5'b01110;
        sw = 16'hA5C3;
        tail = 4'h0;
        step();
        ld = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("rot%0d head", i), 32'(head), 32'(words[i % 4]));
            check($sformatf("rot%0d sof", i), 32'(sof), 32'((i % 4) == 0));
            check($sformatf("rot%0d pos", i), 32'(pos), 32'(i % 4));
            check($sformatf("rot%0d cnt", i), 32'(cnt), 32'(i / 4));
            step();
        end
        check("rot end cnt", 32'(cnt), 32'd3);
        check("rot end head", 32'(head), 32'hA);
        // saturation, then clear and resume at the next wrap
        repeat (80) step();
        check("sat cnt", 32'(cnt), 32'd15);
        check("sat pos", 32'(pos), 32'd0);
        check("sat head", 32'(head), 32'hA);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr cnt", 32'(cnt), 32'd0);
        check("clr pos", 32'(pos), 32'd1);
        step();
        step();
        check("resume pre cnt", 32'(cnt), 32'd0);
        check("resume pre pos", 32'(pos), 32'd3);
        step();
        check("resume cnt", 32'(cnt), 32'd1);
        check("resume head", 32'(head), 32'hA);
        // load mid-frame while shifting
        step();
        step();
        check("mid pos", 32'(pos), 32'd2);
        check("mid head", 32'(head), 32'hC);
        ld = 1'b1;
        sw = 16'h1234;
        step();
        check("load sof masked", 32'(sof), 32'd0);
        ld = 1'b0;
        #1;
        check("load head", 32'(head), 32'h1);
        check("load pos", 32'(pos), 32'd0);
        check("load cnt", 32'(cnt), 32'd0);
        check("load sof", 32'(sof), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
